// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run-control sequencer.
// The state enum and byte-per-word constants are used by the top FSM and the bench.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_DRAIN,
        S_RUN,
        S_DUMP_REQ,
        S_DUMP_WAIT,
        S_DUMP_OUT,
        S_DONE
    } run_state_e;

    localparam int unsigned IMEM_BYTES_PER_WORD = 4;
    localparam int unsigned DMEM_BYTES_PER_WORD = 8;

    // Memory ports take byte addresses; the sequencer counts in words.
    function automatic logic [63:0] word_to_byte_addr(input logic [63:0] word_idx,
                                                      input int unsigned bytes_per_word);
        return word_idx * 64'(bytes_per_word);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Stream and memory-port bundle between the run-control sequencer and its surroundings.
// master is the sequencer side; slave is the host/cpu side.
interface cpu_run_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    logic [63:0] imem_addr;
    logic        imem_wen;
    logic        imem_ren;
    logic [31:0] imem_wdata;

    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic        dmem_ren;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata;

    modport master (
        input  in_valid, in_data, out_ready, dmem_rdata,
        output in_ready, out_valid, out_data,
        output imem_addr, imem_wen, imem_ren, imem_wdata,
        output dmem_addr, dmem_wen, dmem_ren, dmem_wdata
    );

    modport slave (
        output in_valid, in_data, out_ready, dmem_rdata,
        input  in_ready, out_valid, out_data,
        input  imem_addr, imem_wen, imem_ren, imem_wdata,
        input  dmem_addr, dmem_wen, dmem_ren, dmem_wdata
    );

endinterface

// File: rtl/cpu_run_ctrl_run_cycle_counter.sv
// Loadable down-counter with a zero flag; times the enable window of the RUN phase.
// Decrement saturates at zero so a stray dec never wraps.
module run_cycle_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Job sequencer for the pipelined core: load program, run for N cycles, dump a data window.
// Every output is driven from a register so the cpu sees glitch-free strobes.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 10,
    parameter int RUN_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [IMEM_ADDR_W:0]   prog_len_i,
    input  logic [RUN_W-1:0]       run_cycles_i,
    input  logic [DMEM_ADDR_W-1:0] dump_base_i,
    input  logic [DMEM_ADDR_W:0]   dump_len_i,
    cpu_run_ctrl_if.master         bus,
    output logic                   cpu_enable_o,
    output logic                   cpu_arst_n_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [IMEM_ADDR_W:0] IMEM_CAP = {1'b1, {IMEM_ADDR_W{1'b0}}};
    localparam logic [DMEM_ADDR_W:0] DMEM_CAP = {1'b1, {DMEM_ADDR_W{1'b0}}};
    localparam logic [IMEM_ADDR_W:0] IDX_ONE  = (IMEM_ADDR_W + 1)'(1);
    localparam logic [DMEM_ADDR_W:0] J_ONE    = (DMEM_ADDR_W + 1)'(1);
    localparam logic [RUN_W-1:0]     RUN_ONE  = RUN_W'(1);

    run_state_e             state_q, state_d;
    logic [IMEM_ADDR_W:0]   prog_len_q, prog_len_d;
    logic [RUN_W-1:0]       run_cycles_q, run_cycles_d;
    logic [DMEM_ADDR_W-1:0] dump_base_q, dump_base_d;
    logic [DMEM_ADDR_W:0]   dump_len_q, dump_len_d;
    logic [IMEM_ADDR_W:0]   idx_q, idx_d;
    logic [DMEM_ADDR_W:0]   j_q, j_d;

    logic                   in_ready_q, in_ready_d;
    logic                   imem_wen_q, imem_wen_d;
    logic [63:0]            imem_addr_q, imem_addr_d;
    logic [31:0]            imem_wdata_q, imem_wdata_d;
    logic                   dmem_ren_q, dmem_ren_d;
    logic [63:0]            dmem_addr_q, dmem_addr_d;
    logic                   out_valid_q, out_valid_d;
    logic [63:0]            out_data_q, out_data_d;
    logic                   cpu_enable_q, cpu_enable_d;
    logic                   cpu_arst_n_q, cpu_arst_n_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   cnt_load;
    logic [RUN_W-1:0]       cnt_load_val;
    logic                   cnt_dec;
    logic                   cnt_zero;

    logic [IMEM_ADDR_W:0]   prog_len_clamped;
    logic [DMEM_ADDR_W:0]   dump_len_clamped;
    logic [IMEM_ADDR_W:0]   idx_inc;
    logic [DMEM_ADDR_W:0]   j_inc;
    logic [DMEM_ADDR_W-1:0] dump_widx_first;
    logic [DMEM_ADDR_W-1:0] dump_widx_next;

    assign prog_len_clamped = (prog_len_i > IMEM_CAP) ? IMEM_CAP : prog_len_i;
    assign dump_len_clamped = (dump_len_i > DMEM_CAP) ? DMEM_CAP : dump_len_i;
    assign idx_inc          = idx_q + IDX_ONE;
    assign j_inc            = j_q + J_ONE;
    // Word indices wrap naturally at the data-memory depth.
    assign dump_widx_first  = dump_base_q;
    assign dump_widx_next   = dump_base_q + j_inc[DMEM_ADDR_W-1:0];

    run_cycle_counter #(
        .W(RUN_W)
    ) u_run_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        prog_len_d   = prog_len_q;
        run_cycles_d = run_cycles_q;
        dump_base_d  = dump_base_q;
        dump_len_d   = dump_len_q;
        idx_d        = idx_q;
        j_d          = j_q;
        in_ready_d   = in_ready_q;
        imem_wen_d   = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_ren_d   = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        cpu_enable_d = cpu_enable_q;
        cpu_arst_n_d = cpu_arst_n_q;
        busy_d       = busy_q;
        done_d       = done_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    prog_len_d   = prog_len_clamped;
                    run_cycles_d = run_cycles_i;
                    dump_base_d  = dump_base_i;
                    dump_len_d   = dump_len_clamped;
                    idx_d        = '0;
                    j_d          = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    out_valid_d  = 1'b0;
                    cpu_enable_d = 1'b0;
                    cpu_arst_n_d = 1'b0;
                    if (prog_len_clamped == '0) begin
                        state_d = S_LOAD_DRAIN;
                    end else begin
                        state_d    = S_LOAD;
                        in_ready_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    imem_wen_d   = 1'b1;
                    imem_addr_d  = word_to_byte_addr(64'(idx_q), IMEM_BYTES_PER_WORD);
                    imem_wdata_d = bus.in_data;
                    idx_d        = idx_inc;
                    if (idx_inc == prog_len_q) begin
                        in_ready_d = 1'b0;
                        state_d    = S_LOAD_DRAIN;
                    end
                end
            end

            // The counter holds cycles remaining after the current one, so zero marks the last.
            S_LOAD_DRAIN: begin
                if (run_cycles_q != '0) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = run_cycles_q - RUN_ONE;
                    cpu_arst_n_d = 1'b1;
                    cpu_enable_d = 1'b1;
                    state_d      = S_RUN;
                end else if (dump_len_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    dmem_ren_d  = 1'b1;
                    dmem_addr_d = word_to_byte_addr(64'(dump_widx_first), DMEM_BYTES_PER_WORD);
                    state_d     = S_DUMP_REQ;
                end
            end

            S_RUN: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    cpu_enable_d = 1'b0;
                    if (dump_len_q == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dmem_ren_d  = 1'b1;
                        dmem_addr_d = word_to_byte_addr(64'(dump_widx_first), DMEM_BYTES_PER_WORD);
                        state_d     = S_DUMP_REQ;
                    end
                end
            end

            S_DUMP_REQ: begin
                state_d = S_DUMP_WAIT;
            end

            S_DUMP_WAIT: begin
                out_data_d  = bus.dmem_rdata;
                out_valid_d = 1'b1;
                state_d     = S_DUMP_OUT;
            end

            S_DUMP_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    j_d         = j_inc;
                    if (j_inc < dump_len_q) begin
                        dmem_ren_d  = 1'b1;
                        dmem_addr_d = word_to_byte_addr(64'(dump_widx_next), DMEM_BYTES_PER_WORD);
                        state_d     = S_DUMP_REQ;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prog_len_q   <= '0;
            run_cycles_q <= '0;
            dump_base_q  <= '0;
            dump_len_q   <= '0;
            idx_q        <= '0;
            j_q          <= '0;
            in_ready_q   <= 1'b0;
            imem_wen_q   <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_ren_q   <= 1'b0;
            dmem_addr_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            cpu_enable_q <= 1'b0;
            cpu_arst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_len_q   <= prog_len_d;
            run_cycles_q <= run_cycles_d;
            dump_base_q  <= dump_base_d;
            dump_len_q   <= dump_len_d;
            idx_q        <= idx_d;
            j_q          <= j_d;
            in_ready_q   <= in_ready_d;
            imem_wen_q   <= imem_wen_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_ren_q   <= dmem_ren_d;
            dmem_addr_q  <= dmem_addr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            cpu_enable_q <= cpu_enable_d;
            cpu_arst_n_q <= cpu_arst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wen   = imem_wen_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_ren   = dmem_ren_q;
    // Instruction memory is write-only and data memory read-only from this side.
    assign bus.imem_ren   = 1'b0;
    assign bus.dmem_wen   = 1'b0;
    assign bus.dmem_wdata = '0;

    assign cpu_enable_o = cpu_enable_q;
    assign cpu_arst_n_o = cpu_arst_n_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: jobs push expected memory traffic and dump words,
// negedge monitors pop and compare whenever the DUT strobes or presents data.
module tb_cpu_run_ctrl;

    localparam int IW = 9;
    localparam int DW = 10;
    localparam int RW = 32;
    localparam int IMEM_WORDS = 1 << IW;
    localparam int DMEM_WORDS = 1 << DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW:0]   prog_len;
    logic [RW-1:0] run_cycles;
    logic [DW-1:0] dump_base;
    logic [DW:0]   dump_len;
    logic          cpu_enable;
    logic          cpu_arst_n;
    logic          busy;
    logic          done;

    cpu_run_ctrl_if bus();

    cpu_run_ctrl #(
        .IMEM_ADDR_W (IW),
        .DMEM_ADDR_W (DW),
        .RUN_W       (RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .prog_len_i   (prog_len),
        .run_cycles_i (run_cycles),
        .dump_base_i  (dump_base),
        .dump_len_i   (dump_len),
        .bus          (bus),
        .cpu_enable_o (cpu_enable),
        .cpu_arst_n_o (cpu_arst_n),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] a;
        logic [31:0] d;
    } imem_exp_t;

    imem_exp_t   exp_imem[$];
    logic [63:0] exp_rd[$];
    logic [63:0] exp_out[$];
    logic [31:0] prog_words[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int job_seq  = 0;
    int rdy_mode = 0;

    int en_total = 0, ren_in_valid = 0, stalls = 0, bursts = 0, last_wr_cyc = -10;
    int en_base, ren_base, stall_base, burst_base;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model with one-cycle read latency; contents are address<<4.
    always @(posedge clk) begin
        if (rst) bus.dmem_rdata <= '0;
        else if (bus.dmem_ren) bus.dmem_rdata <= bus.dmem_addr << 4;
    end

    // Sink readiness: 0 = always ready, 1 = random, 2 = stall the first word for 5 cycles.
    int seen_seq = -1;
    int hold_cnt = 0;
    always begin
        @(posedge clk);
        #1;
        if (seen_seq != job_seq) begin
            seen_seq = job_seq;
            hold_cnt = 0;
        end
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (bus.out_valid && hold_cnt < 5) begin
                    bus.out_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        imem_exp_t e;
        if (!rst) begin
            if (bus.imem_wen) begin
                if (exp_imem.size() == 0) check("imem_unexpected_wen", bus.imem_wen, 0);
                else begin
                    e = exp_imem.pop_front();
                    check("imem_addr", bus.imem_addr, e.a);
                    check("imem_wdata", 64'(bus.imem_wdata), 64'(e.d));
                end
                check("arst_n_during_load", cpu_arst_n, 0);
                if (cyc != last_wr_cyc + 1) bursts++;
                last_wr_cyc = cyc;
            end
            if (bus.dmem_ren) begin
                if (exp_rd.size() == 0) check("dmem_unexpected_ren", bus.dmem_ren, 0);
                else check("dmem_addr", bus.dmem_addr, exp_rd.pop_front());
                if (bus.out_valid) ren_in_valid++;
            end
            if (bus.out_valid) begin
                if (exp_out.size() == 0) check("out_unexpected_valid", bus.out_valid, 0);
                else begin
                    check("out_data", bus.out_data, exp_out[0]);
                    if (bus.out_ready) void'(exp_out.pop_front());
                    else stalls++;
                end
            end
            if (cpu_enable) begin
                en_total++;
                check("arst_n_during_run", cpu_arst_n, 1);
            end
        end
    end

    task automatic check_idle(input string tag);
        $display("idle check: %s", tag);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_imem_wen", bus.imem_wen, 0);
        check("rst_imem_ren", bus.imem_ren, 0);
        check("rst_imem_addr", bus.imem_addr, 0);
        check("rst_dmem_ren", bus.dmem_ren, 0);
        check("rst_dmem_wen", bus.dmem_wen, 0);
        check("rst_dmem_addr", bus.dmem_addr, 0);
        check("rst_cpu_enable", cpu_enable, 0);
        check("rst_cpu_arst_n", cpu_arst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    task automatic start_job(input int plen, input int runc, input int base, input int dlen,
                             input int gap_max, input int mode);
        int np, nd, gap, t;
        int unsigned wa;
        imem_exp_t e;
        np = (plen > IMEM_WORDS) ? IMEM_WORDS : plen;
        nd = (dlen > DMEM_WORDS) ? DMEM_WORDS : dlen;
        while (prog_words.size() < np) prog_words.push_back($urandom);
        for (int i = 0; i < np; i++) begin
            e.a = 64'(i * 4);
            e.d = prog_words[i];
            exp_imem.push_back(e);
        end
        for (int j = 0; j < nd; j++) begin
            wa = 32'(((base + j) % DMEM_WORDS) * 8);
            exp_rd.push_back(64'(wa));
            exp_out.push_back(64'(wa) * 64'd16);
        end
        $display("job %0d: prog_len=%0d run_cycles=%0d dump_base=%0d dump_len=%0d ready_mode=%0d",
                 job_seq + 1, plen, runc, base, dlen, mode);
        job_seq++;
        rdy_mode   = mode;
        en_base    = en_total;
        ren_base   = ren_in_valid;
        stall_base = stalls;
        burst_base = bursts;
        prog_len   = (IW + 1)'(plen);
        run_cycles = RW'(runc);
        dump_base  = DW'(base);
        dump_len   = (DW + 1)'(dlen);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < np; i++) begin
            gap = $urandom_range(0, gap_max);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = prog_words[i];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.in_ready && t < 64);
            if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
        prog_words.delete();
    endtask

    task automatic finish_job(input int runc, input bit one_burst, input int exp_lat, input int exp_stall);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20000);
        check("done", done, 1);
        check("busy_at_done", busy, 0);
        check("cpu_enable_at_done", cpu_enable, 0);
        check("enable_cycles", 64'(en_total - en_base), 64'(runc));
        check("imem_writes_left", 64'(exp_imem.size()), 0);
        check("dmem_reads_left", 64'(exp_rd.size()), 0);
        check("out_words_left", 64'(exp_out.size()), 0);
        check("ren_while_out_valid", 64'(ren_in_valid - ren_base), 0);
        if (runc > 0) check("arst_n_after_run", cpu_arst_n, 1);
        if (one_burst) check("imem_write_bursts", 64'(bursts - burst_base), 1);
        if (exp_stall >= 0) check("out_stall_cycles", 64'(stalls - stall_base), 64'(exp_stall));
        if (exp_lat >= 0) check("start_to_done", 64'(n), 64'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst          = 1'b1;
        start        = 1'b0;
        prog_len     = '0;
        run_cycles   = '0;
        dump_base    = '0;
        dump_len     = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("after reset");
        @(posedge clk);
        #1;

        // Load three words back to back, run 20 cycles, dump three words from base 2.
        prog_words = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        start_job(3, 20, 2, 3, 0, 0);
        finish_job(20, 1'b1, -1, 0);

        // Sink stalls the first dump word for five cycles.
        start_job(2, 4, 100, 2, 1, 2);
        finish_job(4, 1'b0, -1, 5);

        // Empty job: straight through LOAD_DRAIN to DONE.
        start_job(0, 0, 7, 0, 0, 0);
        finish_job(0, 1'b0, 2, 0);

        // Dump window wrapping past the top of data memory.
        start_job(5, 3, DMEM_WORDS - 2, 4, 2, 1);
        finish_job(3, 1'b0, -1, -1);

        // Oversized lengths clamp to memory capacity.
        start_job(600, 2, 0, 1100, 0, 0);
        finish_job(2, 1'b1, -1, 0);

        for (int k = 0; k < 8; k++) begin
            start_job($urandom_range(0, 8), $urandom_range(0, 25), $urandom_range(0, DMEM_WORDS - 1),
                      $urandom_range(0, 5), 3, 1);
            finish_job(int'(run_cycles), 1'b0, -1, -1);
        end

        // Abort mid-run: a start while busy is ignored, rst together with start wins.
        prog_words = '{32'h00100073};
        start_job(1, 20, 5, 2, 0, 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cpu_enable && t < 50);
        check("run_reached", cpu_enable, 1);
        @(posedge clk);
        #1;
        prog_len   = 11'(4);
        run_cycles = RW'(9);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_start_ignored_busy", busy, 1);
        check("busy_start_ignored_in_ready", bus.in_ready, 0);
        check("busy_start_ignored_enable", cpu_enable, 1);
        check("busy_start_ignored_done", done, 0);
        repeat (4) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        exp_rd.delete();
        exp_out.delete();
        exp_imem.delete();
        @(negedge clk);
        check_idle("abort mid-run");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_abort_busy", busy, 0);
        check("post_abort_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;

        start_job(4, 6, 17, 3, 1, 1);
        finish_job(6, 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Sequencer that drives the pipelined RISC-V core's external memory ports and run control. One job runs per start pulse, in three phases:
- streams a program into instruction memory;
- holds the core in reset, then releases it and asserts enable for a programmed number of cycles;
- reads back a window of data memory as an output stream.
It sits between the testbench or host and the cpu top, and owns addr_ext/wen_ext/ren_ext/wdata_ext, addr_ext_2/ren_ext_2/wen_ext_2, enable and the core's arst_n.

Parameters:
IMEM_ADDR_W, 9, log2 of instruction-memory depth in 32-bit words (prog_len clamps to 2^IMEM_ADDR_W).
DMEM_ADDR_W, 10, log2 of data-memory depth in 64-bit words (dump_len clamps to 2^DMEM_ADDR_W).
RUN_W, 32, width of the run-cycle counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle job start; ignored unless state is IDLE or DONE
prog_len  in  IMEM_ADDR_W+1  number of instruction words to load; sampled on start
run_cycles  in  RUN_W  number of enable cycles; sampled on start
dump_base  in  DMEM_ADDR_W  first data-memory word index to dump; sampled on start
dump_len  in  DMEM_ADDR_W+1  number of 64-bit words to dump; sampled on start
in_valid/in_ready/in_data  in/out/in  1/1/32  program word stream
out_valid/out_ready/out_data  out/in/out  1/1/64  dump stream
imem_addr/imem_wen/imem_ren/imem_wdata  out  64/1/1/32  to the cpu's addr_ext/wen_ext/ren_ext/wdata_ext
dmem_addr/dmem_wen/dmem_ren/dmem_wdata  out  64/1/1/64  to the cpu's addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2
dmem_rdata  in  64  from the cpu's rdata_ext_2
cpu_enable  out  1  to the cpu's enable
cpu_arst_n  out  1  to the cpu's arst_n
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  high in DONE; held until the next accepted start

Behaviour:
- All outputs are registered. Reset values:
  - state=IDLE; all strobes, in_ready, out_valid, cpu_enable, busy, done = 0;
  - cpu_arst_n=0; addresses and data = 0.
- rst is synchronous: it takes effect at the next clk edge from any state and aborts the job; nothing is flushed downstream.
- FSM states: IDLE, LOAD, LOAD_DRAIN, RUN, DUMP_REQ, DUMP_WAIT, DUMP_OUT, DONE.
- Start (in IDLE or DONE):
  - latch all job inputs; clamp lengths to capacity; clear idx;
  - go to LOAD; if prog_len==0, go straight to LOAD_DRAIN.
- LOAD:
  - in_ready=1 and cpu_arst_n=0;
  - each beat with in_valid&&in_ready drives, in the next cycle, imem_wen=1, imem_addr=4*idx, imem_wdata=in_data; then idx++;
  - in the cycle the last beat is accepted, in_ready falls next and state goes to LOAD_DRAIN.
- LOAD_DRAIN: one cycle, used to retire the final write. imem_wen=0. Load run_cnt=run_cycles.
- RUN:
  - cpu_arst_n=1; cpu_enable=1 for exactly run_cycles cycles, counted by run_cnt, then cpu_enable=0;
  - cpu_arst_n stays 1 after RUN so core state is preserved;
  - run_cycles==0 skips RUN: cpu_enable is never asserted.
- DUMP_REQ: dmem_ren=1 for one cycle at dmem_addr=8*(dump_base+j), where j is the dump index.
- DUMP_WAIT: the SRAM has one-cycle read latency; capture dmem_rdata into out_data; out_valid=1.
- DUMP_OUT:
  - out_valid and out_data hold stable until out_ready;
  - on handshake: j++; go to DUMP_REQ if words remain, else DONE.
- dump_len==0 goes from RUN directly to DONE.
- dmem_wen and dmem_wdata are tied 0, and imem_ren is tied 0. No read-modify-write is performed.
- Index arithmetic:
  - dump_base+j wraps modulo 2^DMEM_ADDR_W;
  - address LSBs are zero (byte addresses: 4 per instruction word, 8 per data word).
- Boundary rules:
  - start in any busy state is ignored;
  - start and rst in the same cycle: rst wins;
  - out_ready held high gives throughput of 1 word per 3 cycles.

Decomposition:
- A shared package cpu_run_pkg holds:
  - the state enum;
  - constants IMEM_BYTES_PER_WORD=4 and DMEM_BYTES_PER_WORD=8.
- One natural sub-module, run_cycle_counter: loadable down-counter with a zero flag, used for RUN.
- Everything else stays in the top FSM.

Test Plan:
1. prog_len=3, words 0x00500093/0x00A00113/0x002081B3, in_valid held high -> imem_wen on 3 consecutive cycles, addr 0x0/0x4/0x8 with matching wdata; cpu_arst_n=0 throughout.
2. run_cycles=20 -> cpu_enable high exactly 20 cycles; cpu_arst_n rises in the first RUN cycle and stays high.
3. dump_base=2, dump_len=3, dmem model returns addr<<4, out_ready=1 -> out_data 0x100/0x180/0x200; ren addrs 0x10/0x18/0x20; done high afterwards.
4. out_ready low 5 cycles on word 0 -> out_valid and out_data held stable; no further dmem_ren until the handshake.
5. prog_len=0, run_cycles=0, dump_len=0 -> start to done in 2 cycles (LOAD_DRAIN then DONE); no strobes; cpu_enable never 1.
6. rst asserted mid-RUN at cycle 7 -> next edge: state IDLE, cpu_enable=0, cpu_arst_n=0, busy=0; a start issued while busy is ignored.
